// File: rtl/split128to64.sv
// split128to64: unpacks 128-bit FIFO words into two beats of four 16-bit
// channel samples each. Frame-based: reads exactly `len` words per start.
module split128to64 #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [127:0]     fifo_dout,
    input  logic             ren,
    output logic [15:0]      data1out,
    output logic [15:0]      data2out,
    output logic [15:0]      data3out,
    output logic [15:0]      data4out,
    output logic             dvalid,
    output logic             phase,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] rd_left, out_left;
    logic [127:0]     w, p;
    logic             w_valid, p_valid, inflight;
    logic [1:0]       held;
    logic             accept, vacate;

    assign held    = {1'b0, w_valid} + {1'b0, p_valid} + {1'b0, inflight};
    assign fifo_rd = (state == RUN) && (rd_left != '0) && !fifo_empty && (held < 2'd2);
    assign accept  = w_valid & ren;
    assign vacate  = accept & phase;
    assign dvalid  = w_valid;
    assign busy    = (state == RUN);

    // FSM state register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next-state: leave RUN when the final beat of the final word is taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && (len != '0)) state_nxt = RUN;
            RUN:  if (vacate && (out_left == LEN_W'(1))) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, word storage (W current, P prefetch), phase and done pulse
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_left  <= '0;
            out_left <= '0;
            w        <= '0;
            p        <= '0;
            w_valid  <= 1'b0;
            p_valid  <= 1'b0;
            inflight <= 1'b0;
            phase    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= fifo_rd;
            if (state == IDLE) begin
                if (start) begin
                    if (len == '0) begin
                        done <= 1'b1;
                    end else begin
                        rd_left  <= len;
                        out_left <= len;
                    end
                end
            end else begin
                if (fifo_rd) rd_left <= rd_left - LEN_W'(1);
                if (accept) phase <= ~phase;
                if (vacate) begin
                    out_left <= out_left - LEN_W'(1);
                    if (out_left == LEN_W'(1)) done <= 1'b1;
                end
                // W refills from P first, then from arriving read data
                if (vacate) begin
                    if (p_valid) begin
                        w <= p;
                        if (inflight) p <= fifo_dout;
                        else          p_valid <= 1'b0;
                    end else if (inflight) begin
                        w <= fifo_dout;
                    end else begin
                        w_valid <= 1'b0;
                    end
                end else if (inflight) begin
                    if (!w_valid) begin
                        w       <= fifo_dout;
                        w_valid <= 1'b1;
                    end else begin
                        p       <= fifo_dout;
                        p_valid <= 1'b1;
                    end
                end
            end
        end
    end

    // Output mux: even halfwords on phase 0, odd halfwords on phase 1
    always_comb begin
        if (!phase) begin
            data1out = w[15:0];
            data2out = w[47:32];
            data3out = w[79:64];
            data4out = w[111:96];
        end else begin
            data1out = w[31:16];
            data2out = w[63:48];
            data3out = w[95:80];
            data4out = w[127:112];
        end
    end

endmodule

// File: tb/tb_split128to64.sv
// Testbench for split128to64: directed frames, scoreboard-checked beats.
module tb_split128to64;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  len = '0;
    logic         fifo_empty;
    logic         fifo_rd;
    logic [127:0] fifo_dout = '0;
    logic         ren = 1'b1;
    logic [15:0]  data1out, data2out, data3out, data4out;
    logic         dvalid, phase, busy, done;

    split128to64 #(.LEN_W(16)) dut (
        .clk(clk), .clr(clr), .start(start), .len(len),
        .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
        .ren(ren), .data1out(data1out), .data2out(data2out),
        .data3out(data3out), .data4out(data4out),
        .dvalid(dvalid), .phase(phase), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // FIFO model (non-FWFT: data appears after the read edge)
    logic [127:0] fq[$];
    int push_n = 0;
    int pop_n = 0;
    logic force_empty = 1'b0;
    assign fifo_empty = force_empty | (push_n == pop_n);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd && fq.size() > 0) begin
            fifo_dout <= fq.pop_front();
            pop_n = pop_n + 1;
        end
    end

    // Scoreboard: {phase, d1, d2, d3, d4}
    logic [64:0] exp_q[$];
    logic [64:0] exp_e, cur_beat, held_beat;
    logic        hold_pending = 1'b0;

    int rd_cnt, done_cnt, beat_cnt, dv_cnt, first_dv, last_dv, last_beat_cyc, done_cyc;
    int rd_total = 0, vac_total = 0;
    int start_cyc;
    bit dv_seen, gap_seen;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [127:0] mk(input logic [15:0] base);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = base + 16'(k);
        return r;
    endfunction

    task automatic push_raw(input logic [127:0] wd, input logic [63:0] b0, input logic [63:0] b1);
        fq.push_back(wd);
        push_n = push_n + 1;
        exp_q.push_back({1'b0, b0});
        exp_q.push_back({1'b1, b1});
    endtask

    task automatic push_word(input logic [127:0] wd);
        push_raw(wd, {wd[15:0], wd[47:32], wd[79:64], wd[111:96]},
                     {wd[31:16], wd[63:48], wd[95:80], wd[127:112]});
    endtask

    task automatic clear_stats();
        rd_cnt = 0; done_cnt = 0; beat_cnt = 0; dv_cnt = 0;
        first_dv = -1; last_dv = -1; last_beat_cyc = -1; done_cyc = -1;
        dv_seen = 0; gap_seen = 0;
    endtask

    task automatic start_frame(input logic [15:0] l);
        @(posedge clk); #1;
        start = 1'b1; len = l; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound, input bit bp);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin
            @(posedge clk); #1;
            if (bp) ren = (n % 4 == 0) || (n % 4 == 3);
            n++;
        end
        ren = 1'b1;
        check({name, "_done_seen"}, done_cnt > 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctrl"}, {fifo_rd, dvalid, phase, busy, done}, 5'b0);
        check({name, "_data"}, {data1out, data2out, data3out, data4out}, 64'h0);
    endtask

    // Monitor: beat checking, hold stability, read occupancy, counters
    always @(negedge clk) begin
        if (clr) begin
            cur_beat = {phase, data1out, data2out, data3out, data4out};
            if (fifo_rd) begin
                rd_cnt++;
                check("occupancy_at_read", (rd_total - vac_total) <= 1, 1'b1);
                rd_total++;
            end
            if (force_empty) check("rd_in_empty_window", fifo_rd, 1'b0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (hold_pending) begin
                check("hold_valid", dvalid, 1'b1);
                check("hold_beat", cur_beat, held_beat);
            end
            if (dvalid) begin
                if (!dv_seen) first_dv = cyc;
                dv_seen = 1;
                last_dv = cyc;
                dv_cnt++;
            end else if (busy && dv_seen) begin
                gap_seen = 1;
            end
            if (dvalid && ren) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got %0h expected none", cur_beat);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("beat", cur_beat, exp_e);
                end
                beat_cnt++;
                last_beat_cyc = cyc;
                if (phase) vac_total++;
            end
            hold_pending = dvalid && !ren;
            held_beat = cur_beat;
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        clr = 1'b1;
        @(posedge clk); #1;

        // Single word, len=1
        clear_stats();
        push_raw(128'h0008_0007_0006_0005_0004_0003_0002_0001,
                 64'h0001_0003_0005_0007, 64'h0002_0004_0006_0008);
        start_frame(16'd1);
        wait_done("single", 50, 1'b0);
        check("single_rd_cnt", rd_cnt, 1);
        check("single_beats", beat_cnt, 2);
        check("single_done_cnt", done_cnt, 1);
        check("single_done_timing", done_cyc, last_beat_cyc + 1);
        check("single_latency", first_dv - start_cyc, 3);
        check("single_sb_empty", exp_q.size(), 0);

        // Streaming, len=4
        clear_stats();
        for (int i = 0; i < 4; i++) push_word(mk(16'h1000 + 16'(i * 16'h100)));
        start_frame(16'd4);
        wait_done("stream", 100, 1'b0);
        check("stream_rd_cnt", rd_cnt, 4);
        check("stream_beats", beat_cnt, 8);
        check("stream_dv_cycles", dv_cnt, 8);
        check("stream_span", last_dv - first_dv, 7);
        check("stream_no_gap", gap_seen, 1'b0);
        check("stream_done_cnt", done_cnt, 1);
        check("stream_busy_after", busy, 1'b0);
        check("stream_sb_empty", exp_q.size(), 0);

        // Backpressure, len=3, ren pattern 1,0,0,1
        clear_stats();
        for (int i = 0; i < 3; i++) push_word(mk(16'h2000 + 16'(i * 16'h100)));
        start_frame(16'd3);
        wait_done("bp", 200, 1'b1);
        check("bp_rd_cnt", rd_cnt, 3);
        check("bp_beats", beat_cnt, 6);
        check("bp_sb_empty", exp_q.size(), 0);

        // FIFO empty for 5 cycles mid-frame, len=4
        clear_stats();
        for (int i = 0; i < 4; i++) push_word(mk(16'h3000 + 16'(i * 16'h100)));
        start_frame(16'd4);
        @(posedge clk);
        @(posedge clk); #1;
        force_empty = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        force_empty = 1'b0;
        wait_done("empty", 100, 1'b0);
        check("empty_rd_cnt", rd_cnt, 4);
        check("empty_beats", beat_cnt, 8);
        check("empty_gap_seen", gap_seen, 1'b1);
        check("empty_sb_empty", exp_q.size(), 0);

        // len=0 start
        clear_stats();
        start_frame(16'd0);
        repeat (3) @(posedge clk);
        #1;
        check("len0_done_cnt", done_cnt, 1);
        check("len0_rd_cnt", rd_cnt, 0);
        check("len0_busy", busy, 1'b0);

        // Second start while busy is ignored
        clear_stats();
        for (int i = 0; i < 2; i++) push_word(mk(16'h4000 + 16'(i * 16'h100)));
        start_frame(16'd2);
        @(posedge clk); #1;
        start = 1'b1; len = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("restart", 100, 1'b0);
        check("restart_rd_cnt", rd_cnt, 2);
        check("restart_beats", beat_cnt, 4);
        check("restart_done_cnt", done_cnt, 1);
        check("restart_busy_after", busy, 1'b0);

        // clr pulsed mid-frame after 3 beats
        clear_stats();
        for (int i = 0; i < 4; i++) push_word(mk(16'h5000 + 16'(i * 16'h100)));
        start_frame(16'd4);
        begin
            int n = 0;
            while (beat_cnt < 3 && n < 50) begin
                @(posedge clk);
                n++;
            end
        end
        check("clr_reach_3_beats", beat_cnt, 3);
        @(posedge clk); #3;
        clr = 1'b0;
        #1;
        check_idle_outputs("clr_async");
        exp_q.delete();
        fq.delete();
        push_n = pop_n;
        rd_total = 0;
        vac_total = 0;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        check("clr_idle_busy", busy, 1'b0);
        clear_stats();
        push_word(mk(16'h6000));
        start_frame(16'd1);
        wait_done("post_clr", 50, 1'b0);
        check("post_clr_rd_cnt", rd_cnt, 1);
        check("post_clr_beats", beat_cnt, 2);
        check("post_clr_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
